// File: rtl/uart_pkg.sv
// Shared UART definitions: TX sequencer states, tx_mux select codes, and
// counter sizing helper used by the TX controller and the baud counter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_DATA   = 2'b01;
  localparam logic [1:0] SEL_PARITY = 2'b10;
  localparam logic [1:0] SEL_STOP   = 2'b11;

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: pulses bit_end on the last clock of each bit period.
// Held at zero while disabled; restart forces the next period to begin at zero.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic bit_end
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  assign bit_end = enable && (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!enable || restart || bit_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: walks start, data (LSB first), optional parity and
// stop phases, one bit period each, steering tx_mux via select/data_bit/parity_bit.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  output logic [1:0]            select,
  output logic                  data_bit,
  output logic                  parity_bit,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BW = cnt_w(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  uart_state_e           r_state;
  uart_state_e           w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [BW-1:0]         r_bit_cnt;
  logic                  r_par_en;
  logic                  r_parity_bit;
  logic                  w_accept;
  logic                  w_bit_end;
  logic                  w_restart;
  logic                  w_baud_en;

  assign w_accept  = tx_valid && (r_state == IDLE);
  assign w_baud_en = (r_state != IDLE);
  // Every state change starts a fresh bit period.
  assign w_restart = (w_state_nxt != r_state);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .enable (w_baud_en),
    .restart(w_restart),
    .bit_end(w_bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (tx_valid) w_state_nxt = START;
      START:   if (w_bit_end) w_state_nxt = DATA;
      DATA:    if (w_bit_end && (r_bit_cnt == LAST_BIT))
                 w_state_nxt = r_par_en ? PARITY : STOP;
      PARITY:  if (w_bit_end) w_state_nxt = STOP;
      STOP:    if (w_bit_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Frame contents are captured once at accept; inputs are ignored afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_par_en     <= 1'b0;
      r_parity_bit <= 1'b0;
    end else if (w_accept) begin
      r_shreg      <= tx_data;
      r_par_en     <= parity_en;
      r_parity_bit <= (^tx_data) ^ parity_odd;
      r_bit_cnt    <= '0;
    end else if ((r_state == START) && w_bit_end) begin
      r_bit_cnt <= '0;
    end else if ((r_state == DATA) && w_bit_end) begin
      r_shreg   <= r_shreg >> 1;
      r_bit_cnt <= r_bit_cnt + BW'(1);
    end
  end

  always_comb begin
    select   = SEL_STOP;
    data_bit = 1'b0;
    busy     = 1'b1;
    tx_ready = 1'b0;
    tx_done  = 1'b0;
    case (r_state)
      IDLE: begin
        busy     = 1'b0;
        tx_ready = 1'b1;
      end
      START:  select = SEL_START;
      DATA: begin
        select   = SEL_DATA;
        data_bit = r_shreg[0];
      end
      PARITY: select = SEL_PARITY;
      STOP:   tx_done = w_bit_end;
      default: begin
        busy     = 1'b0;
        tx_ready = 1'b1;
      end
    endcase
  end

  assign parity_bit = r_parity_bit;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a frame-level model expands each accepted byte into
// its per-cycle line picture; a monitor compares the DUT against it every cycle.
module tb_uart_tx_ctrl;

  localparam int DW  = 8;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic          parity_en = 1'b0;
  logic          parity_odd = 1'b0;
  logic [1:0]    select;
  logic          data_bit;
  logic          parity_bit;
  logic          busy;
  logic          tx_done;

  uart_tx_ctrl #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .select    (select),
    .data_bit  (data_bit),
    .parity_bit(parity_bit),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic       dbit;
    logic       pchk;
    logic       pbit;
    logic       busy;
    logic       rdy;
    logic       done;
  } vec_t;

  vec_t m_wave[$];
  vec_t exp_q[$];
  logic m_idle = 1'b1;
  int   m_acc_cnt = 0;
  int   dut_done_cnt = 0;
  int   total = 0;
  int   bad = 0;
  vec_t mon_e;
  vec_t mon_a;

  function automatic vec_t idle_vec();
    vec_t v;
    v = '{sel: 2'b11, dbit: 1'b0, pchk: 1'b0, pbit: 1'b0, busy: 1'b0, rdy: 1'b1, done: 1'b0};
    return v;
  endfunction

  task automatic add_phase(input logic [1:0] sel, input logic dbit, input logic pbit,
                           input logic is_stop);
    vec_t v;
    for (int c = 0; c < CPB; c++) begin
      v = '{sel: sel, dbit: dbit, pchk: (sel == 2'b10), pbit: pbit, busy: 1'b1,
            rdy: 1'b0, done: (is_stop && c == CPB - 1)};
      m_wave.push_back(v);
    end
  endtask

  task automatic build_frame(input logic [DW-1:0] d, input logic pen, input logic podd);
    logic p;
    p = podd;
    for (int i = 0; i < DW; i++) p = p ^ d[i];
    add_phase(2'b00, 1'b0, p, 1'b0);
    for (int i = 0; i < DW; i++) add_phase(2'b01, d[i], p, 1'b0);
    if (pen) add_phase(2'b10, 1'b0, p, 1'b0);
    add_phase(2'b11, 1'b0, p, 1'b1);
  endtask

  // Model: at each edge decide what the line must look like in the next cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_wave.delete();
      m_idle <= 1'b1;
    end else begin
      if (m_wave.size() == 0 && m_idle && tx_valid) begin
        build_frame(tx_data, parity_en, parity_odd);
        m_acc_cnt <= m_acc_cnt + 1;
      end
      if (m_wave.size() > 0) begin
        exp_q.push_back(m_wave.pop_front());
        m_idle <= 1'b0;
      end else begin
        exp_q.push_back(idle_vec());
        m_idle <= 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
      end else begin
        if (tx_done) dut_done_cnt++;
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          if (!mon_e.pchk) mon_e.pbit = 1'b0;
          mon_a = '{sel: select, dbit: data_bit, pchk: mon_e.pchk,
                    pbit: (mon_e.pchk ? parity_bit : 1'b0), busy: busy, rdy: tx_ready,
                    done: tx_done};
          total++;
          if (mon_a !== mon_e) begin
            bad++;
            $display("FAIL line_cycle t=%0t got sel=%b dbit=%b pbit=%b busy=%b rdy=%b done=%b want sel=%b dbit=%b pbit=%b busy=%b rdy=%b done=%b",
                     $time, mon_a.sel, mon_a.dbit, mon_a.pbit, mon_a.busy, mon_a.rdy, mon_a.done,
                     mon_e.sel, mon_e.dbit, mon_e.pbit, mon_e.busy, mon_e.rdy, mon_e.done);
          end
        end
      end
    end
  end

  task automatic check_reset_vals(input string name);
    logic [6:0] act;
    act = {select, data_bit, parity_bit, busy, tx_ready, tx_done};
    total++;
    if (act !== 7'b11_0_0_0_1_0) begin
      bad++;
      $display("FAIL %s got {sel,dbit,pbit,busy,rdy,done}=%b want 1100010", name, act);
    end
  endtask

  task automatic scramble_inputs();
    tx_data    = DW'($urandom);
    parity_en  = 1'($urandom);
    parity_odd = 1'($urandom);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic pen, input logic podd);
    int c0;
    int n;
    c0 = m_acc_cnt;
    tx_data = d; parity_en = pen; parity_odd = podd; tx_valid = 1'b1;
    n = 0;
    while (m_acc_cnt == c0 && n < 300) begin
      @(negedge clk); n++;
    end
    if (m_acc_cnt == c0) begin
      total++; bad++;
      $display("FAIL accept_wait got no accept want accept within 300 cycles");
    end
  endtask

  task automatic wait_idle(input bit scramble);
    int n;
    n = 0;
    while (!(m_wave.size() == 0 && m_idle) && n < 300) begin
      @(negedge clk); n++;
      if (scramble) scramble_inputs();
    end
    if (!(m_wave.size() == 0 && m_idle)) begin
      total++; bad++;
      $display("FAIL idle_wait got frame still open want idle within 300 cycles");
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish want finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    #12;
    check_reset_vals("reset_hold");
    @(negedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    send(8'hA5, 1'b1, 1'b0);
    tx_valid = 1'b0;
    wait_idle(1'b0);

    send(8'h00, 1'b0, 1'b1);
    tx_valid = 1'b0;
    wait_idle(1'b0);
    send(8'h00, 1'b1, 1'b1);
    tx_valid = 1'b0;
    wait_idle(1'b0);

    // Back-to-back with tx_valid held, then stray valid pulses mid-frame.
    d0 = dut_done_cnt;
    send(8'h3C, 1'b1, 1'b0);
    send(8'hC3, 1'b0, 1'b1);
    tx_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat (3) @(negedge clk);
      tx_data = DW'($urandom); tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
    end
    wait_idle(1'b0);
    @(negedge clk);
    total++;
    if (dut_done_cnt - d0 != 2) begin
      bad++;
      $display("FAIL b2b_done_count got %0d want 2", dut_done_cnt - d0);
    end

    // Reset in the middle of data bit 3.
    send(8'h5A, 1'b1, 1'b1);
    tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1 check_reset_vals("reset_midframe");
    @(negedge clk);
    @(negedge clk); #1 rst = 1'b0;
    @(negedge clk);

    send(8'h96, 1'b1, 1'b1);
    tx_valid = 1'b0;
    wait_idle(1'b1);

    for (int f = 0; f < 16; f++) begin
      send(DW'($urandom), 1'($urandom), 1'($urandom));
      tx_valid = 1'b0;
      wait_idle(1'b1);
      tx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
